// File: rtl/key_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : key_scan_encoder
// Function : N active-low keys -> sync, tick-sampled debounce, lowest-index
//            single-key encode with accept strobe, held level and multi flag.
//            Build option: `define KEY_REPEAT_EN adds auto-repeat strobes.
// Revision : 1.0  initial release
// ============================================================================
module key_scan_encoder #(
  parameter int N_KEYS      = 16,
  parameter int CODE_W      = 4,
  parameter int TICK_DIV    = 2000,
  parameter int DEB_SAMPLES = 4,
  parameter int REPEAT_DLY  = 250,
  parameter int REPEAT_RATE = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              pressed,
  output logic              multi
);

  localparam int         c_TICK_W   = $clog2(TICK_DIV);
  localparam logic [7:0] c_DEB      = 8'(DEB_SAMPLES);
  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_DEBOUNCE = 2'd1;
  localparam logic [1:0] c_HELD     = 2'd2;
  localparam logic [1:0] c_RELEASE  = 2'd3;

  // Elaboration-time parameter sanity checks
  if ((1 << CODE_W) < N_KEYS) begin : g_bad_code_w
    $error("key_scan_encoder: CODE_W too narrow for N_KEYS");
  end
  if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("key_scan_encoder: REPEAT_DLY and REPEAT_RATE must be >= 1");
  end

  logic [N_KEYS-1:0]   r_key_meta;
  logic [N_KEYS-1:0]   r_ks;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [1:0]          r_state;
  logic [7:0]          r_cnt;
  logic [CODE_W-1:0]   r_cand;
  logic [CODE_W-1:0]   r_code;
  logic                r_valid;
  logic                r_pressed;
  logic                r_multi;

  logic                w_tick;
  logic [N_KEYS-1:0]   w_low;
  logic                w_none;
  logic                w_is_multi;
  logic                w_single;
  logic [CODE_W-1:0]   w_idx;
  logic                w_same;
  logic                w_match_cand;
  logic [7:0]          w_cnt_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_meta <= '1;
      r_ks       <= '1;
    end else begin
      r_key_meta <= key;
      r_ks       <= r_key_meta;
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  // Clearing the lowest set bit leaves a nonzero value only for 2+ presses
  assign w_low      = ~r_ks;
  assign w_none     = (w_low == '0);
  assign w_is_multi = ((w_low & (w_low - N_KEYS'(1))) != '0);
  assign w_single   = !w_none && !w_is_multi;

  always_comb begin
    w_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_low[i]) begin
        w_idx = CODE_W'(i);
      end
    end
  end

  assign w_same       = w_single && (w_idx == r_code);
  assign w_match_cand = w_single && (w_idx == r_cand);
  assign w_cnt_inc    = r_cnt + 8'd1;

`ifdef KEY_REPEAT_EN
  logic [31:0] r_rep_cnt;
  logic [31:0] w_rep_next;
  logic        w_rep_wrap;
  logic        w_rep_fire;

  assign w_rep_next = r_rep_cnt + 32'd1;
  assign w_rep_wrap = (w_rep_next == 32'(REPEAT_DLY + REPEAT_RATE));
  assign w_rep_fire = (w_rep_next == 32'(REPEAT_DLY)) || w_rep_wrap;

  // Counts held ticks; folds back to REPEAT_DLY so later strobes recur every REPEAT_RATE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep_cnt <= '0;
    end else if (r_state != c_HELD) begin
      r_rep_cnt <= '0;
    end else if (w_tick && w_same) begin
      r_rep_cnt <= w_rep_wrap ? 32'(REPEAT_DLY) : w_rep_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_cand    <= '0;
      r_code    <= '1;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick) begin
        r_multi <= w_is_multi;
        case (r_state)
          c_IDLE: begin
            if (w_single) begin
              r_cand <= w_idx;
              r_cnt  <= 8'd1;
              if (c_DEB == 8'd1) begin
                r_code    <= w_idx;
                r_pressed <= 1'b1;
                r_valid   <= 1'b1;
                r_state   <= c_HELD;
              end else begin
                r_state <= c_DEBOUNCE;
              end
            end
          end
          c_DEBOUNCE: begin
            if (w_match_cand) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == c_DEB) begin
                r_code    <= r_cand;
                r_pressed <= 1'b1;
                r_valid   <= 1'b1;
                r_state   <= c_HELD;
              end
            end else if (w_single) begin
              r_cand <= w_idx;
              r_cnt  <= 8'd1;
            end else begin
              r_state <= c_IDLE;
            end
          end
          c_HELD: begin
            if (w_same) begin
`ifdef KEY_REPEAT_EN
              if (w_rep_fire) begin
                r_valid <= 1'b1;
              end
`endif
            end else if (c_DEB == 8'd1) begin
              r_pressed <= 1'b0;
              r_state   <= c_IDLE;
            end else begin
              r_cnt   <= 8'd1;
              r_state <= c_RELEASE;
            end
          end
          c_RELEASE: begin
            if (w_same) begin
              r_state <= c_HELD;
            end else if (w_cnt_inc == c_DEB) begin
              r_pressed <= 1'b0;
              r_state   <= c_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_valid;
  assign pressed    = r_pressed;
  assign multi      = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_key_scan_encoder.sv
`default_nettype none
// Scoreboard bench for key_scan_encoder: expected accept codes are queued as
// keys are driven and popped when code_valid fires.
module tb_key_scan_encoder;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] key;
  logic [3:0]  code;
  logic        code_valid, pressed, multi;
  logic [4:0]  key2;
  logic [2:0]  code2;
  logic        code_valid2, pressed2, multi2;

  int   total = 0;
  int   bad = 0;
  int   extra = 0;
  int   strobes2 = 0;
  int   cyc = 0;
  int   tb_tcnt = 0;
  int   first_cyc = 0;
  int   drive_cyc = 0;
  bit   first_seen = 1'b0;
  logic [3:0] exp_q[$];

  key_scan_encoder #(
    .N_KEYS(16), .CODE_W(4), .TICK_DIV(TICK), .DEB_SAMPLES(3),
    .REPEAT_DLY(5), .REPEAT_RATE(2)
  ) u_dut (
    .clk(clk), .reset(reset), .key(key), .code(code),
    .code_valid(code_valid), .pressed(pressed), .multi(multi)
  );

  key_scan_encoder #(
    .N_KEYS(5), .CODE_W(3), .TICK_DIV(TICK), .DEB_SAMPLES(3)
  ) u_dut5 (
    .clk(clk), .reset(reset), .key(key2), .code(code2),
    .code_valid(code_valid2), .pressed(pressed2), .multi(multi2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) tb_tcnt <= 0;
    else        tb_tcnt <= (tb_tcnt == TICK - 1) ? 0 : tb_tcnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && code_valid) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (exp_q.size() > 0) check_val("sb_code", 32'(code), 32'(exp_q.pop_front()));
      else extra++;
    end
    if (reset && code_valid2) strobes2++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves us 1 time unit after a tick edge (both counters just wrapped to 0)
  task automatic align();
    do begin
      @(posedge clk);
      #1;
    end while (tb_tcnt != 0);
  endtask

  task automatic drain(input string tag);
    check_val({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_extra"}, 32'(extra), 32'd0);
    exp_q.delete();
    extra = 0;
  endtask

  initial begin
    reset = 1'b0;
    key   = '1;
    key2  = '1;
    cycles(3);
    check_val("rst_code", 32'(code), 32'hF);
    check_val("rst_valid", 32'(code_valid), 32'd0);
    check_val("rst_pressed", 32'(pressed), 32'd0);
    check_val("rst_multi", 32'(multi), 32'd0);
    check_val("rst_code5", 32'(code2), 32'h7);
    reset = 1'b1;
    cycles(8);
    drain("idle");

    // single key 2 held 20 ticks, then released
    align();
    first_seen = 1'b0;
    key = 16'hFFFB;
    drive_cyc = cyc;
    exp_q.push_back(4'd2);
`ifdef KEY_REPEAT_EN
    repeat (7) exp_q.push_back(4'd2);
`endif
    cycles(11);
    check_val("t2_pre_accept", 32'(pressed), 32'd0);
    cycles(1);
    check_val("t2_pressed", 32'(pressed), 32'd1);
    check_val("t2_code", 32'(code), 32'd2);
    cycles(68);
    check_val("t2_held", 32'(pressed), 32'd1);
    check_val("t2_latency_ok", 32'(first_seen && ((first_cyc - drive_cyc) <= 15)), 32'd1);
    key = 16'hFFFF;
    cycles(11);
    check_val("t2_rel_hold", 32'(pressed), 32'd1);
    cycles(1);
    check_val("t2_released", 32'(pressed), 32'd0);
    check_val("t2_code_kept", 32'(code), 32'd2);
    drain("t2");

    // short press of key 5 is rejected
    align();
    key = 16'hFFDF;
    cycles(8);
    key = 16'hFFFF;
    cycles(20);
    check_val("t3_short", 32'(pressed), 32'd0);
    drain("t3a");

    // bouncing key 5, then stable
    align();
    for (int i = 0; i < 4; i++) begin
      key = 16'hFFDF;
      cycles(TICK);
      key = 16'hFFFF;
      cycles(TICK);
    end
    key = 16'hFFDF;
    exp_q.push_back(4'd5);
    cycles(20);
    check_val("t3_code", 32'(code), 32'd5);
    check_val("t3_pressed", 32'(pressed), 32'd1);
    key = 16'hFFFF;
    cycles(20);
    check_val("t3_rel", 32'(pressed), 32'd0);
    drain("t3b");

    // two keys, then one
    align();
    key = 16'hFFFC;
    cycles(3);
    check_val("t4_multi_pre", 32'(multi), 32'd0);
    cycles(1);
    check_val("t4_multi_set", 32'(multi), 32'd1);
    cycles(8);
    check_val("t4_multi_hold", 32'(multi), 32'd1);
    check_val("t4_no_press", 32'(pressed), 32'd0);
    key = 16'hFFFE;
    exp_q.push_back(4'd0);
    cycles(4);
    check_val("t4_multi_clr", 32'(multi), 32'd0);
    check_val("t4_not_yet", 32'(pressed), 32'd0);
    cycles(8);
    check_val("t4_pressed", 32'(pressed), 32'd1);
    check_val("t4_code", 32'(code), 32'd0);
    key = 16'hFFFF;
    cycles(20);
    check_val("t4_rel", 32'(pressed), 32'd0);
    drain("t4");

    // top key indices on both widths, plus a one-tick glitch while held
    align();
    key  = 16'h7FFF;
    key2 = 5'b01111;
    exp_q.push_back(4'hF);
    cycles(16);
    check_val("t5_code15", 32'(code), 32'hF);
    check_val("t5_pressed", 32'(pressed), 32'd1);
    check_val("t5_code5", 32'(code2), 32'd4);
    check_val("t5_pressed5", 32'(pressed2), 32'd1);
    key = 16'hFFFF;
    cycles(TICK);
    check_val("t5_glitch", 32'(pressed), 32'd1);
    key = 16'h7FFF;
    cycles(12);
    check_val("t5_after_glitch", 32'(pressed), 32'd1);
    check_val("t5_code_kept", 32'(code), 32'hF);
    key  = 16'hFFFF;
    key2 = 5'b11111;
    cycles(20);
    check_val("t5_rel", 32'(pressed), 32'd0);
    check_val("t5_strobes5", 32'(strobes2), 32'd1);
    drain("t5");

    // key 7 held 12 ticks past acceptance
    align();
    key = 16'hFF7F;
    exp_q.push_back(4'd7);
`ifdef KEY_REPEAT_EN
    repeat (4) exp_q.push_back(4'd7);
`endif
    cycles(60);
    check_val("t6_code", 32'(code), 32'd7);
    check_val("t6_pressed", 32'(pressed), 32'd1);
    key = 16'hFFFF;
    cycles(20);
    check_val("t6_rel", 32'(pressed), 32'd0);
    drain("t6");

    // reset in the middle of debouncing key 3
    align();
    key = 16'hFFF7;
    cycles(8);
    reset = 1'b0;
    #1;
    check_val("t1b_code", 32'(code), 32'hF);
    check_val("t1b_valid", 32'(code_valid), 32'd0);
    check_val("t1b_pressed", 32'(pressed), 32'd0);
    check_val("t1b_multi", 32'(multi), 32'd0);
    key = 16'hFFFF;
    cycles(3);
    reset = 1'b1;
    cycles(24);
    check_val("t1b_idle", 32'(pressed), 32'd0);
    check_val("t1b_code_kept", 32'(code), 32'hF);
    drain("t1b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
